dcache_wb_buffer: RTL and testbench
===================================

Name: dcache_wb_buffer

Overview:
- Write-back / uncached-store buffer between the dcache and the AXI bridge's dcache write port.
- Accepts evicted dirty lines (128-bit) and uncached stores from the dcache, queues them, and drains them in order into the bridge.
- Gives the dcache an address-hazard check so a refill read never overtakes a queued write to the same line.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  dcache pushes an entry.
- in_ready  out  1  buffer can accept; equals !full (or merge hit when merge is compiled in).
- in_type  in  3  000 byte, 001 half, 010 word, 100 line.
- in_addr  in  32  byte address; line entries are 16-byte aligned.
- in_wstrb  in  4  byte strobes; ignored for line entries.
- in_data  in  128  line data; word entries use [31:0].
- chk_addr  in  32  dcache read-miss address under test.
- chk_hazard  out  1  chk_addr line matches a queued entry.
- empty  out  1  no entries queued.
- dcache_wr_req  out  1  to bridge.
- dcache_wr_type  out  3  to bridge.
- dcache_wr_addr  out  32  to bridge.
- dcache_wr_wstrb  out  4  to bridge.
- dcache_wr_data  out  128  to bridge.
- dcache_wr_rdy  in  1  bridge idle and able to accept.

Behaviour:
- Storage: circular FIFO of DEPTH entries {type, addr, wstrb, data}, plus wr_ptr, rd_ptr and count (PTR_W+1 bits).
- Reset (aresetn low at posedge aclk):
  - Pointers and count go to 0; entry valid bits are cleared.
  - Outputs: dcache_wr_req=0, in_ready=1, empty=1, chk_hazard=0. Data outputs are don't-care but are driven from cleared storage (0).
- Push:
  - Accepted on the posedge where in_valid && in_ready.
  - The entry is written at wr_ptr, wr_ptr increments (wraps modulo DEPTH), count increments.
  - Visible at the head no earlier than the next cycle, so latency from push to dcache_wr_req on an empty buffer is 1 cycle.
- Drain:
  - dcache_wr_req = (count != 0); dcache_wr_* are taken from entry[rd_ptr].
  - Handshake = dcache_wr_req && dcache_wr_rdy. On handshake, rd_ptr increments and count decrements.
  - Head outputs stay stable while the request is pending.
  - The bridge drops wr_rdy the cycle after the handshake. The buffer needs no extra gap; the next entry is offered immediately and waits for rdy.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - in_ready uses only current count: when full, a push is refused even in a pop cycle.
- Full: count==DEPTH → in_ready=0. Empty: count==0 → empty=1, dcache_wr_req=0.
- Ordering: strictly FIFO. The bridge serialises AW/W/B, so a write handed to the bridge completes before any later bridge read.
- Hazard:
  - chk_hazard is combinational: OR over valid entries of (entry.addr[31:4] == chk_addr[31:4]). The match applies to line and word entries alike.
  - An entry in its handshake cycle still counts (conservative). A same-cycle push does not count; the dcache must not check against its own push.
- Reset mid-operation: queued entries are discarded without issue. The bridge is reset in the same domain.
- No X on outputs after reset; assert no push when !in_ready and no change of head outputs while req && !rdy.

Optional Feature:
- Macro DCACHE_WB_MERGE_EN.
- Defined:
  - A non-line push whose addr[31:2] equals the youngest entry's addr[31:2] merges into that entry. This applies only when the youngest entry is non-line and count ≥ 2, so the youngest is never the head being offered.
  - Merge rules: bytes with in_wstrb set overwrite; wstrb |= in_wstrb; type becomes 010; count unchanged.
  - in_ready = !full || merge_hit.
- Undefined: every push allocates a new entry.

Decomposition:
- Shared package/header (mycpu.h): localparams for type codes (TYPE_BYTE=000, TYPE_HALF=001, TYPE_WORD=010, TYPE_LINE=100), LINE_OFF_W=4, WB_ENTRY_W=167.
- One natural sub-module: wb_addr_cmp, a per-entry valid&&line-address comparator vector reduced by OR.

Test Plan:
- Push line addr 0x1C000040 into empty buffer, dcache_wr_rdy=1 → wr_req high next cycle with addr 0x1C000040, type 100; popped on that cycle; empty=1 after.
- DEPTH=2, rdy=0, push 3 words 0x100/0x104/0x108 → third refused (in_ready=0); raise rdy → drained in order 0x100 then 0x104.
- Queued line 0x2000, chk_addr=0x200C → chk_hazard=1; chk_addr=0x2010 → 0; after handshake cycle → 0.
- Full buffer with push and handshake in same cycle → push refused, count 2→1, next cycle in_ready=1.
- Merge feature: queue word 0x300 wstrb 0001 data 0xAA behind another entry, push 0x300 wstrb 0100 data 0x00BB0000 → single entry wstrb 0101 data 0x00BB00AA; without macro → two entries.
- Assert aresetn low with 2 entries pending → wr_req=0, empty=1 next cycle; no bridge request issued.

Source files
------------

// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types and constants for the dcache write-back / uncached-store buffer.
// Entry layout is {type, addr, wstrb, data} = 3 + 32 + 4 + 128 bits.
package dcache_wb_buffer_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int LINE_OFF_W  = 4;
  localparam int LINE_ADDR_W = 32 - LINE_OFF_W;
  localparam int WB_ENTRY_W  = 167;

  typedef struct packed {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wb_entry_t;

  // Byte-lane overwrite of a 32-bit word: lanes with strb set take new_w.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_addr_cmp.sv
// Line-address hazard comparator: flags a match between the checked line
// and any valid buffered entry, reduced by OR.
module wb_addr_cmp
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic [DEPTH-1:0]       i_valid,
  input  logic [LINE_ADDR_W-1:0] i_entry_line [DEPTH],
  input  logic [LINE_ADDR_W-1:0] i_chk_line,
  output logic                   o_hit
);

  logic [DEPTH-1:0] w_match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_match[g] = i_valid[g] && (i_entry_line[g] == i_chk_line);
  end

  assign o_hit = |w_match;

endmodule

// File: rtl/dcache_wb_buffer.sv
// In-order write-back / uncached-store FIFO between the dcache and the AXI bridge.
// Define DCACHE_WB_MERGE_EN to merge sub-line stores into the youngest entry.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_type,
  input  logic [31:0]  in_addr,
  input  logic [3:0]   in_wstrb,
  input  logic [127:0] in_data,
  input  logic [31:0]  chk_addr,
  output logic         chk_hazard,
  output logic         empty,
  output logic         dcache_wr_req,
  output logic [2:0]   dcache_wr_type,
  output logic [31:0]  dcache_wr_addr,
  output logic [3:0]   dcache_wr_wstrb,
  output logic [127:0] dcache_wr_data,
  input  logic         dcache_wr_rdy
);

  localparam logic [PTR_W:0] CNT_FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_MERGE_MIN = (PTR_W+1)'(2);

  wb_entry_t              r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;

  wb_entry_t              w_head;
  wb_entry_t              w_new;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_merge_hit;
  logic [LINE_ADDR_W-1:0] w_entry_line [DEPTH];
  logic                   w_unused;

  assign w_full  = (r_count == CNT_FULL);
  assign empty   = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  assign dcache_wr_req   = !empty;
  assign dcache_wr_type  = w_head.wtype;
  assign dcache_wr_addr  = w_head.addr;
  assign dcache_wr_wstrb = w_head.wstrb;
  assign dcache_wr_data  = w_head.data;

  assign w_new = '{wtype: in_type, addr: in_addr, wstrb: in_wstrb, data: in_data};

`ifdef DCACHE_WB_MERGE_EN
  logic [PTR_W-1:0] w_young_ptr;
  wb_entry_t        w_young;
  wb_entry_t        w_merged;
  logic             w_merge;

  // count >= 2 keeps the merge target away from the head being offered.
  assign w_young_ptr = r_wr_ptr - PTR_W'(1);
  assign w_young     = r_mem[w_young_ptr];
  assign w_merge_hit = (in_type != TYPE_LINE) && (r_count >= CNT_MERGE_MIN) &&
                       (w_young.wtype != TYPE_LINE) &&
                       (w_young.addr[31:2] == in_addr[31:2]);
  assign w_merge     = in_valid && w_merge_hit;

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    w_merged                = w_young;
    w_merged.wtype          = TYPE_WORD;
    w_merged.wstrb          = w_young.wstrb | in_wstrb;
    w_merged.data[31:0]     = merge_word(w_young.data[31:0], in_data[31:0], in_wstrb);
  end
`else
  assign w_merge_hit = 1'b0;
`endif

  assign in_ready = !w_full || w_merge_hit;
  assign w_push   = in_valid && in_ready && !w_merge_hit;
  assign w_pop    = dcache_wr_req && dcache_wr_rdy;

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      // NOTE: storage is small and drives the data outputs directly, so it is
      // reset to keep those outputs defined; large RAMs would not be reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_mem[r_wr_ptr]   <= w_new;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
`ifdef DCACHE_WB_MERGE_EN
      if (w_merge) begin
        r_mem[w_young_ptr] <= w_merged;
      end
`endif
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_line
    assign w_entry_line[g] = r_mem[g].addr[31:LINE_OFF_W];
  end

  wb_addr_cmp #(
    .DEPTH        (DEPTH)
  ) u_addr_cmp (
    .i_valid      (r_valid),
    .i_entry_line (w_entry_line),
    .i_chk_line   (chk_addr[31:LINE_OFF_W]),
    .o_hit        (chk_hazard)
  );

  // Only the line part of the checked address takes part in the hazard compare.
  assign w_unused = ^chk_addr[LINE_OFF_W-1:0];

  a_no_push_when_busy : assert property (@(posedge aclk) disable iff (!aresetn)
    !in_ready |=> (r_wr_ptr == $past(r_wr_ptr)));

  a_head_stable : assert property (@(posedge aclk) disable iff (!aresetn)
    (dcache_wr_req && !dcache_wr_rdy) |=> $stable(w_head));

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Scoreboard bench for dcache_wb_buffer: pushes queue expected entries,
// the bridge-side monitor pops and compares them on each handshake.
`timescale 1ns/1ps
module tb_dcache_wb_buffer;
  import dcache_wb_buffer_pkg::*;

  localparam int DEPTH = 2;

  logic         aclk;
  logic         aresetn;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_type;
  logic [31:0]  in_addr;
  logic [3:0]   in_wstrb;
  logic [127:0] in_data;
  logic [31:0]  chk_addr;
  logic         chk_hazard;
  logic         empty;
  logic         dcache_wr_req;
  logic [2:0]   dcache_wr_type;
  logic [31:0]  dcache_wr_addr;
  logic [3:0]   dcache_wr_wstrb;
  logic [127:0] dcache_wr_data;
  logic         dcache_wr_rdy;

  wb_entry_t sb_q[$];
  wb_entry_t mon_e;
  int        n_checks = 0;
  int        n_fail   = 0;

  dcache_wb_buffer #(.DEPTH(DEPTH)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_type         (in_type),
    .in_addr         (in_addr),
    .in_wstrb        (in_wstrb),
    .in_data         (in_data),
    .chk_addr        (chk_addr),
    .chk_hazard      (chk_hazard),
    .empty           (empty),
    .dcache_wr_req   (dcache_wr_req),
    .dcache_wr_type  (dcache_wr_type),
    .dcache_wr_addr  (dcache_wr_addr),
    .dcache_wr_wstrb (dcache_wr_wstrb),
    .dcache_wr_data  (dcache_wr_data),
    .dcache_wr_rdy   (dcache_wr_rdy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit model_merge_hit(input logic [2:0] t, input logic [31:0] a);
`ifdef DCACHE_WB_MERGE_EN
    if (sb_q.size() < 2 || t == TYPE_LINE) return 1'b0;
    return (sb_q[sb_q.size()-1].wtype != TYPE_LINE) &&
           (sb_q[sb_q.size()-1].addr[31:2] == a[31:2]);
`else
    return (t === 3'bxxx) && (a === 32'hx);
`endif
  endfunction

  function automatic bit model_hazard(input logic [31:0] a);
    foreach (sb_q[i]) begin
      if (sb_q[i].addr[31:4] == a[31:4]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Bridge-side monitor: a handshake happens at the next posedge.
  always @(negedge aclk) begin
    if (aresetn && dcache_wr_req && dcache_wr_rdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", 1'b1, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_type",  dcache_wr_type,  mon_e.wtype);
        check("wr_addr",  dcache_wr_addr,  mon_e.addr);
        check("wr_wstrb", dcache_wr_wstrb, mon_e.wstrb);
        check("wr_data",  dcache_wr_data,  mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Called at posedge+1; expectations are taken from the model before the
  // monitor can pop this cycle's handshake.
  task automatic push(input string tag, input logic [2:0] t, input logic [31:0] a,
                      input logic [3:0] s, input logic [127:0] d);
    bit        exp_merge;
    bit        exp_acc;
    bit        exp_hz;
    bit        exp_empty;
    wb_entry_t e;
    exp_merge = model_merge_hit(t, a);
    exp_acc   = (sb_q.size() < DEPTH) || exp_merge;
    exp_hz    = model_hazard(chk_addr);
    exp_empty = (sb_q.size() == 0);
    in_valid = 1'b1; in_type = t; in_addr = a; in_wstrb = s; in_data = d;
    @(negedge aclk);
    check({tag, "_ready"},  in_ready,   exp_acc);
    check({tag, "_hazard"}, chk_hazard, exp_hz);
    check({tag, "_empty"},  empty,      exp_empty);
    @(posedge aclk);
    if (exp_acc) begin
      if (exp_merge) begin
        e = sb_q.pop_back();
        e.wtype = TYPE_WORD;
        for (int b = 0; b < 4; b++) begin
          if (s[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
        end
        e.wstrb = e.wstrb | s;
        sb_q.push_back(e);
      end else begin
        sb_q.push_back('{wtype: t, addr: a, wstrb: s, data: d});
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dcache_wr_rdy = 1'b1;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    dcache_wr_rdy = 1'b0;
    check({tag, "_left"}, sb_q.size(), 0);
    @(negedge aclk);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_req"},   dcache_wr_req, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; in_valid = 1'b0; in_type = '0; in_addr = '0; in_wstrb = '0;
    in_data = '0; chk_addr = '0; dcache_wr_rdy = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_req",    dcache_wr_req, 1'b0);
    check("rst_ready",  in_ready,      1'b1);
    check("rst_empty",  empty,         1'b1);
    check("rst_hazard", chk_hazard,    1'b0);
    check("rst_data",   dcache_wr_data, 128'h0);
    check("rst_no_x",   $isunknown({in_ready, chk_hazard, empty, dcache_wr_req, dcache_wr_type,
                                    dcache_wr_addr, dcache_wr_wstrb, dcache_wr_data}), 1'b0);
    tick();
    aresetn = 1'b1;

    // Line push into empty buffer with the bridge ready: 1-cycle latency, then popped.
    dcache_wr_rdy = 1'b1;
    push("t1_line", TYPE_LINE, 32'h1C00_0040, 4'hF, 128'h0123456789ABCDEF_FEDCBA9876543210);
    @(negedge aclk);
    check("t1_req", dcache_wr_req, 1'b1);
    tick();
    @(negedge aclk);
    check("t1_empty_after", empty, 1'b1);
    check("t1_req_after",   dcache_wr_req, 1'b0);
    dcache_wr_rdy = 1'b0;
    tick();

    // Three words into a two-deep buffer with the bridge stalled.
    push("t2_w0", TYPE_WORD, 32'h100, 4'hF, 128'h1111_1111);
    push("t2_w1", TYPE_WORD, 32'h104, 4'hF, 128'h2222_2222);
    push("t2_w2", TYPE_WORD, 32'h108, 4'hF, 128'h3333_3333);
    drain("t2");

    // Hazard: same-cycle push ignored, line match, mismatch, handshake cycle, after.
    chk_addr = 32'h2000;
    push("t3_line", TYPE_LINE, 32'h2000, 4'h0, 128'hA5A5);
    chk_addr = 32'h200C;
    @(negedge aclk);
    check("t3_hz_match", chk_hazard, 1'b1);
    tick();
    chk_addr = 32'h2010;
    @(negedge aclk);
    check("t3_hz_next_line", chk_hazard, 1'b0);
    tick();
    chk_addr = 32'h200C;
    dcache_wr_rdy = 1'b1;
    @(negedge aclk);
    check("t3_hz_in_hs", chk_hazard, 1'b1);
    tick();
    dcache_wr_rdy = 1'b0;
    @(negedge aclk);
    check("t3_hz_after", chk_hazard, 1'b0);
    tick();

    // Full buffer: push refused even while the head handshakes.
    push("t4_w0", TYPE_WORD, 32'h400, 4'hF, 128'h4040);
    push("t4_w1", TYPE_WORD, 32'h410, 4'hF, 128'h4141);
    dcache_wr_rdy = 1'b1;
    push("t4_line", TYPE_LINE, 32'h800, 4'h0, 128'h8080);
    dcache_wr_rdy = 1'b0;
    @(negedge aclk);
    check("t4_ready_after", in_ready, 1'b1);
    check("t4_req_after",   dcache_wr_req, 1'b1);
    tick();
    drain("t4");

    // Partial stores to the same word behind another entry.
    push("t5_other", TYPE_WORD, 32'h500, 4'hF, 128'h5555_5555);
    push("t5_b0",    TYPE_BYTE, 32'h300, 4'b0001, 128'h0000_00AA);
    push("t5_b2",    TYPE_BYTE, 32'h300, 4'b0100, 128'h00BB_0000);
`ifndef DCACHE_WB_MERGE_EN
    dcache_wr_rdy = 1'b1;
    tick();
    dcache_wr_rdy = 1'b0;
    push("t5_b2_retry", TYPE_BYTE, 32'h300, 4'b0100, 128'h00BB_0000);
`endif
    drain("t5");

    // Reset with two entries pending: nothing may reach the bridge.
    chk_addr = 32'h600;
    push("t6_w0", TYPE_WORD, 32'h600, 4'hF, 128'h6060);
    push("t6_w1", TYPE_WORD, 32'h604, 4'hF, 128'h6161);
    aresetn = 1'b0;
    tick();
    sb_q.delete();
    aresetn = 1'b1;
    @(negedge aclk);
    check("t6_req",    dcache_wr_req, 1'b0);
    check("t6_empty",  empty,         1'b1);
    check("t6_ready",  in_ready,      1'b1);
    check("t6_hazard", chk_hazard,    1'b0);
    dcache_wr_rdy = 1'b1;
    repeat (4) tick();
    dcache_wr_rdy = 1'b0;
    @(negedge aclk);
    check("t6_req_idle", dcache_wr_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
